// File: rtl/tinker_mem_arbiter_if.sv
// tinker_mem_arbiter_if: fetch/data request-grant, response and memory-port signals of the arbiter
interface tinker_mem_arbiter_if;
   logic        if_req;
   logic [63:0] if_addr;
   logic        if_gnt;
   logic        if_rvalid;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [63:0] d_addr;
   logic [63:0] d_wdata;
   logic        d_gnt;
   logic        d_rvalid;
   logic [63:0] d_rdata;
   logic        err;
   logic        m_en;
   logic        m_we;
   logic [63:0] m_addr;
   logic [63:0] m_wdata;
   logic [63:0] m_rdata;
   logic        busy;
   modport slave (
      input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, err,
             m_en, m_we, m_addr, m_wdata, busy
   );
   modport master (
      output if_req, if_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
      input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata, err,
             m_en, m_we, m_addr, m_wdata, busy
   );
endinterface

// File: rtl/tinker_mem_arbiter.sv
// tinker_mem_arbiter: single-port memory arbiter between instruction fetch and data access
module tinker_mem_arbiter #(
   parameter int          MEM_LATENCY  = 2,
   parameter logic [63:0] MEM_BYTES    = 64'd524288,
   parameter int          STARVE_LIMIT = 4
) (
   input logic                 clk,
   input logic                 reset,
   tinker_mem_arbiter_if.slave bus
);
   localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
   logic [1:0]  state;
   logic [2:0]  lat_cnt;
   logic [3:0]  starve_cnt;
   logic        owner_f, oor_r, idle, starved, f_gnt, d_gnt, if_oor, d_oor;
   logic [31:0] if_rdata_r;
   logic [63:0] d_rdata_r;
   // one bit wider so addresses near 2^64 cannot wrap back into range
   assign if_oor = {1'b0, bus.if_addr} + 65'd3 >= {1'b0, MEM_BYTES};
   assign d_oor  = {1'b0, bus.d_addr} + 65'd7 >= {1'b0, MEM_BYTES};
   assign idle    = state == IDLE && !reset;
   assign starved = starve_cnt == 4'(STARVE_LIMIT);
   assign f_gnt   = idle && bus.if_req && (starved || !bus.d_req);
   assign d_gnt   = idle && bus.d_req && !f_gnt;
   assign bus.if_gnt    = f_gnt;
   assign bus.d_gnt     = d_gnt;
   assign bus.m_en      = f_gnt ? !if_oor : d_gnt && !d_oor;
   assign bus.m_we      = d_gnt && bus.d_we && !d_oor;
   assign bus.m_addr    = !bus.m_en ? '0 : f_gnt ? bus.if_addr : bus.d_addr;
   assign bus.m_wdata   = bus.m_we ? bus.d_wdata : '0;
   assign bus.if_rvalid = state == RESP && owner_f;
   assign bus.d_rvalid  = state == RESP && !owner_f;
   assign bus.err       = (state == RESP && oor_r) || (d_gnt && bus.d_we && d_oor);
   assign bus.if_rdata  = if_rdata_r;
   assign bus.d_rdata   = d_rdata_r;
   assign bus.busy      = state != IDLE;
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state      <= IDLE;
         lat_cnt    <= '0;
         starve_cnt <= '0;
         owner_f    <= 1'b0;
         oor_r      <= 1'b0;
         if_rdata_r <= '0;
         d_rdata_r  <= '0;
      end else begin
         starve_cnt <= f_gnt ? 4'd0 : bus.if_req && !starved ? starve_cnt + 4'd1 : starve_cnt;
         if (state == IDLE && (f_gnt || (d_gnt && !bus.d_we))) begin
            state   <= WAIT;
            lat_cnt <= 3'(MEM_LATENCY);
            owner_f <= f_gnt;
            oor_r   <= f_gnt ? if_oor : d_oor;
         end else if (state == WAIT) begin
            lat_cnt <= lat_cnt - 3'd1;
            if (lat_cnt == 3'd1) begin
               state <= RESP;
               if (owner_f) if_rdata_r <= oor_r ? '0 : bus.m_rdata[31:0];
               else d_rdata_r <= oor_r ? '0 : bus.m_rdata;
            end
         end else if (state != IDLE) state <= IDLE;
      end
endmodule

// File: tb/tb_tinker_mem_arbiter.sv
// tb_tinker_mem_arbiter: directed and randomized bench for the fetch/data memory arbiter
module tb_tinker_mem_arbiter;
   localparam int          LAT  = 2;
   localparam logic [63:0] MB   = 64'd524288;
   localparam int          LIM  = 4;
   localparam logic [63:0] JUNK = 64'hBADC_0FFE_E0DD_F00D;
   localparam logic [63:0] PRE  = 64'h8800_0000_1234_5678;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   tinker_mem_arbiter_if bus();
   tinker_mem_arbiter #(.MEM_LATENCY(LAT), .MEM_BYTES(MB), .STARVE_LIMIT(LIM))
      dut (.clk(clk), .reset(reset), .bus(bus));

   int tests = 0, fails = 0;
   function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endfunction

   // background contents of bytes never written
   function automatic logic [7:0] dflt(logic [63:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h3C;
   endfunction

   logic [7:0] mem [longint unsigned];
   logic [7:0] ref_mem [longint unsigned];

   function automatic logic [63:0] env_rd(logic [63:0] a);
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++)
         v[8*i +: 8] = mem.exists(a + 64'(i)) ? mem[a + 64'(i)] : dflt(a + 64'(i));
      return v;
   endfunction

   function automatic logic [63:0] ref_rd(logic [63:0] a);
      logic [63:0] v = '0;
      for (int i = 0; i < 8; i++)
         v[8*i +: 8] = ref_mem.exists(a + 64'(i)) ? ref_mem[a + 64'(i)] : dflt(a + 64'(i));
      return v;
   endfunction

   // memory array: writes at the edge, read data valid only in the cycle LAT after issue
   logic [64:0] pipe [LAT];
   initial begin
      logic [63:0] w;
      w = PRE;
      for (int i = 0; i < 8; i++) mem[64'h2000 + 64'(i)] = w[8*i +: 8];
      for (int i = 0; i < LAT; i++) pipe[i] = '0;
      bus.m_rdata = JUNK;
      forever begin
         @(posedge clk);
         if (bus.m_en && bus.m_we)
            for (int i = 0; i < 8; i++) mem[bus.m_addr + 64'(i)] = bus.m_wdata[8*i +: 8];
         for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = {bus.m_en && !bus.m_we, bus.m_addr};
         bus.m_rdata <= pipe[LAT-1][64] ? env_rd(pipe[LAT-1][63:0]) : JUNK;
      end
   end

   typedef struct {int iss; int at; bit f; logic [63:0] data; bit err;} rsp_t;
   rsp_t q[$];
   int cyc = 0;

   // monitor: predicts grants from an occupancy/starvation model, scoreboards responses
   initial begin
      bit idle, ef, ed, f_oor, d_oor, m_en_e, mwe_e, err_e, fv_e, dv_e, busy_e;
      logic [63:0] ma_e, mw_e, tmp, w;
      logic [31:0] hold_if;
      logic [63:0] hold_d;
      int free_at, starve;
      rsp_t r;
      w = PRE;
      for (int i = 0; i < 8; i++) ref_mem[64'h2000 + 64'(i)] = w[8*i +: 8];
      free_at = 0; starve = 0; hold_if = '0; hold_d = '0;
      forever begin
         @(negedge clk);
         cyc++;
         if (reset) begin
            q.delete();
            free_at = cyc + 1; starve = 0; hold_if = '0; hold_d = '0;
         end else begin
            idle  = cyc >= free_at;
            f_oor = ({1'b0, bus.if_addr} + 65'd3) >= {1'b0, MB};
            d_oor = ({1'b0, bus.d_addr} + 65'd7) >= {1'b0, MB};
            ef = idle && bus.if_req && (starve == LIM || !bus.d_req);
            ed = idle && bus.d_req && !ef;
            chk("if_gnt", 64'(bus.if_gnt), 64'(ef));
            chk("d_gnt", 64'(bus.d_gnt), 64'(ed));
            m_en_e = 0; mwe_e = 0; ma_e = '0; mw_e = '0; err_e = 0;
            if (ef) begin
               tmp = ref_rd(bus.if_addr);
               m_en_e = !f_oor; ma_e = f_oor ? '0 : bus.if_addr;
               r.iss = cyc; r.at = cyc + LAT + 1; r.f = 1; r.err = f_oor;
               r.data = f_oor ? '0 : {32'h0, tmp[31:0]};
               q.push_back(r);
               free_at = cyc + LAT + 2;
            end else if (ed && bus.d_we) begin
               m_en_e = !d_oor; mwe_e = !d_oor; err_e = d_oor;
               ma_e = d_oor ? '0 : bus.d_addr; mw_e = d_oor ? '0 : bus.d_wdata;
               if (!d_oor)
                  for (int i = 0; i < 8; i++) ref_mem[bus.d_addr + 64'(i)] = bus.d_wdata[8*i +: 8];
               free_at = cyc + 1;
            end else if (ed) begin
               m_en_e = !d_oor; ma_e = d_oor ? '0 : bus.d_addr;
               r.iss = cyc; r.at = cyc + LAT + 1; r.f = 0; r.err = d_oor;
               r.data = d_oor ? '0 : ref_rd(bus.d_addr);
               q.push_back(r);
               free_at = cyc + LAT + 2;
            end
            busy_e = q.size() != 0 && cyc > q[0].iss;
            fv_e = 0; dv_e = 0;
            if (q.size() != 0 && q[0].at == cyc) begin
               r = q.pop_front();
               fv_e = r.f; dv_e = !r.f; err_e = r.err;
               if (r.f) hold_if = r.data[31:0];
               else hold_d = r.data;
            end
            chk("m_en", 64'(bus.m_en), 64'(m_en_e));
            chk("m_we", 64'(bus.m_we), 64'(mwe_e));
            chk("m_addr", bus.m_addr, ma_e);
            chk("m_wdata", bus.m_wdata, mw_e);
            chk("err", 64'(bus.err), 64'(err_e));
            chk("if_rvalid", 64'(bus.if_rvalid), 64'(fv_e));
            chk("d_rvalid", 64'(bus.d_rvalid), 64'(dv_e));
            chk("if_rdata", 64'(bus.if_rdata), 64'(hold_if));
            chk("d_rdata", bus.d_rdata, hold_d);
            chk("busy", 64'(bus.busy), 64'(busy_e));
            if (ef) starve = 0;
            else if (bus.if_req && starve < LIM) starve++;
         end
      end
   end

   bit f_pend = 0, d_pend = 0, d_sticky = 0, rnd = 0;

   task automatic drive();
      bus.if_req = f_pend;
      bus.d_req  = d_pend;
   endtask

   function automatic logic [63:0] rand_addr();
      int s = int'($urandom_range(0, 9));
      return s == 0 ? MB - 64'($urandom_range(0, 15)) :
             s == 1 ? 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15)) :
             s == 2 ? 64'($urandom_range(0, 32'h7FFFF)) :
                      64'h1_0000 + 64'($urandom_range(0, 63));
   endfunction

   // one cycle: retire granted requests, optionally create new ones, drive after the edge
   task automatic step();
      @(negedge clk);
      if (bus.if_gnt) f_pend = 0;
      if (bus.d_gnt && !d_sticky) d_pend = 0;
      @(posedge clk);
      #1;
      if (rnd) begin
         if (!f_pend && $urandom_range(0, 2) == 0) begin
            f_pend = 1; bus.if_addr = rand_addr();
         end
         if (!d_pend && $urandom_range(0, 1) == 0) begin
            d_pend = 1; bus.d_we = 1'($urandom_range(0, 1));
            bus.d_addr = rand_addr(); bus.d_wdata = {$urandom, $urandom};
         end
      end
      drive();
   endtask

   task automatic settle();
      int n = 0;
      while ((f_pend || d_pend) && n < 100) begin
         step();
         n++;
      end
      chk("grant_timeout", 64'(f_pend || d_pend), 64'd0);
   endtask

   task automatic chk_zero(string tag);
      chk({tag, "_if_gnt"}, 64'(bus.if_gnt), 64'd0);
      chk({tag, "_d_gnt"}, 64'(bus.d_gnt), 64'd0);
      chk({tag, "_if_rvalid"}, 64'(bus.if_rvalid), 64'd0);
      chk({tag, "_d_rvalid"}, 64'(bus.d_rvalid), 64'd0);
      chk({tag, "_if_rdata"}, 64'(bus.if_rdata), 64'd0);
      chk({tag, "_d_rdata"}, bus.d_rdata, 64'd0);
      chk({tag, "_err"}, 64'(bus.err), 64'd0);
      chk({tag, "_m_en"}, 64'(bus.m_en), 64'd0);
      chk({tag, "_m_we"}, 64'(bus.m_we), 64'd0);
      chk({tag, "_m_addr"}, bus.m_addr, 64'd0);
      chk({tag, "_m_wdata"}, bus.m_wdata, 64'd0);
      chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = '0; bus.d_wdata = '0;
      repeat (3) @(posedge clk);
      #1;
      bus.if_req = 1; bus.d_req = 1; bus.d_we = 1;
      #1;
      chk_zero("reset");
      bus.if_req = 0; bus.d_req = 0; bus.d_we = 0;
      reset = 0;
      repeat (2) step();

      // fetch of the preloaded word
      f_pend = 1; bus.if_addr = 64'h2000; drive();
      settle();
      repeat (3) @(negedge clk);
      chk("fetch_rvalid_t3", 64'(bus.if_rvalid), 64'd1);
      chk("fetch_rdata", 64'(bus.if_rdata), 64'h1234_5678);
      @(posedge clk); #1;

      // simultaneous fetch and load: data first, fetch after the load completes
      f_pend = 1; bus.if_addr = 64'h3000;
      d_pend = 1; bus.d_we = 0; bus.d_addr = 64'h8000; drive();
      settle();
      repeat (LAT + 2) step();

      // continuous stores against a waiting fetch
      f_pend = 1; bus.if_addr = 64'h4000;
      d_pend = 1; d_sticky = 1; bus.d_we = 1; bus.d_addr = 64'h1_0080; bus.d_wdata = 64'h0123_4567_89AB_CDEF;
      drive();
      n = 0;
      while (f_pend && n < 50) begin
         step();
         n++;
      end
      chk("starve_denied", 64'(n - 1), 64'(LIM));
      d_sticky = 0; d_pend = 0; drive();
      repeat (LAT + 3) step();

      // store then load back
      d_pend = 1; bus.d_we = 1; bus.d_addr = 64'h1_0000; bus.d_wdata = 64'hDEAD_BEEF_0000_0001; drive();
      settle();
      d_pend = 1; bus.d_we = 0; drive();
      settle();
      repeat (3) @(negedge clk);
      chk("load_rvalid", 64'(bus.d_rvalid), 64'd1);
      chk("load_rdata", bus.d_rdata, 64'hDEAD_BEEF_0000_0001);
      @(posedge clk); #1;

      // load overrunning the end of memory
      d_pend = 1; bus.d_we = 0; bus.d_addr = 64'h7FFFC; drive();
      settle();
      repeat (3) @(negedge clk);
      chk("oor_rvalid", 64'(bus.d_rvalid), 64'd1);
      chk("oor_rdata", bus.d_rdata, 64'd0);
      chk("oor_err", 64'(bus.err), 64'd1);
      @(posedge clk); #1;

      // reset while a load is in flight
      d_pend = 1; bus.d_we = 0; bus.d_addr = 64'h8000; drive();
      settle();
      reset = 1;
      #1;
      chk_zero("midread");
      @(posedge clk); #1;
      reset = 0;
      repeat (6) step();
      f_pend = 1; bus.if_addr = 64'h2000; drive();
      settle();
      repeat (3) @(negedge clk);
      chk("post_reset_rvalid", 64'(bus.if_rvalid), 64'd1);
      chk("post_reset_rdata", 64'(bus.if_rdata), 64'h1234_5678);
      @(posedge clk); #1;

      rnd = 1;
      repeat (1500) step();
      rnd = 0;
      settle();
      repeat (LAT + 3) step();
      chk("queue_drained", 64'(q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
